// File: rtl/trdb_packet_emitter_q.sv
// Trace packet emitter: packs F3.0/F3.1/F2/F1 payloads LSB-first, tracks the
// last emitted address for delta encoding, and buffers packets in a small FIFO.
module trdb_packet_emitter_q #(
  parameter  int XLEN       = 32,
  parameter  int PRIV_LEN   = 2,
  parameter  int CAUSE_LEN  = 5,
  parameter  int BMAP_LEN   = 31,
  parameter  int FIFO_DEPTH = 4,
  localparam int PAYLOAD_W  = 7 + PRIV_LEN + CAUSE_LEN + 2*XLEN,
  localparam int LEN_W      = $clog2(PAYLOAD_W/8 + 2),
  localparam int OCC_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  input  logic [1:0]           format_i,
  input  logic [1:0]           subformat_i,
  input  logic                 full_address_i,
  input  logic                 branch_i,
  input  logic                 interrupt_i,
  input  logic                 thaddr_i,
  input  logic                 updiscon_i,
  input  logic [PRIV_LEN-1:0]  priv_i,
  input  logic [CAUSE_LEN-1:0] cause_i,
  input  logic [XLEN-1:0]      iaddr_i,
  input  logic [XLEN-1:0]      tval_i,
  input  logic [4:0]           branches_i,
  input  logic [BMAP_LEN-1:0]  branch_map_i,
  output logic                 pkt_valid_o,
  input  logic                 pkt_ready_i,
  output logic [PAYLOAD_W-1:0] pkt_payload_o,
  output logic [LEN_W-1:0]     pkt_len_o,
  output logic                 branch_map_flush_o,
  output logic                 overflow_o,
  output logic                 lost_o,
  input  logic                 clear_lost_i,
  output logic [OCC_W-1:0]     occupancy_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] F_SYNC       = 2'd3;
  localparam logic [1:0] F_ADDR_ONLY  = 2'd2;
  localparam logic [1:0] F_DIFF_DELTA = 2'd1;
  localparam logic [1:0] SF_START     = 2'd0;
  localparam logic [1:0] SF_TRAP      = 2'd1;

  localparam int F30_BITS = 5 + PRIV_LEN + XLEN;
  localparam int F31_BITS = PAYLOAD_W;
  localparam int F2_BITS  = XLEN + 4;
  localparam int F1A_BITS = 9 + BMAP_LEN + XLEN;
  localparam int F1M_BITS = 7 + BMAP_LEN;

  localparam logic [LEN_W-1:0] F30_LEN = LEN_W'((F30_BITS + 7) / 8);
  localparam logic [LEN_W-1:0] F31_LEN = LEN_W'((F31_BITS + 7) / 8);
  localparam logic [LEN_W-1:0] F2_LEN  = LEN_W'((F2_BITS + 7) / 8);
  localparam logic [LEN_W-1:0] F1A_LEN = LEN_W'((F1A_BITS + 7) / 8);
  localparam logic [LEN_W-1:0] F1M_LEN = LEN_W'((F1M_BITS + 7) / 8);

  logic [XLEN-1:0]      latest_q, latest_d;
  logic [OCC_W-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic                 lost_q, lost_d;
  logic [PAYLOAD_W-1:0] pay_mem_q [FIFO_DEPTH];
  logic [LEN_W-1:0]     len_mem_q [FIFO_DEPTH];

  logic [XLEN-1:0]      addr;
  logic                 notify, upd_bit;
  logic                 supported, carries_addr;
  logic [PAYLOAD_W-1:0] payload_d;
  logic [LEN_W-1:0]     len_d;
  logic                 full, pop, wr_en;

  // Packet assembly from the current request.
  always_comb begin
    addr         = full_address_i ? iaddr_i : iaddr_i - latest_q;
    notify       = addr[XLEN-1];
    upd_bit      = addr[XLEN-1] ^ updiscon_i;
    // NOTE: every output of this block gets a default first so no path infers a latch.
    supported    = 1'b0;
    carries_addr = 1'b0;
    payload_d    = '0;
    len_d        = '0;
    case (format_i)
      F_SYNC: begin
        if (subformat_i == SF_START) begin
          supported    = 1'b1;
          carries_addr = 1'b1;
          payload_d    = PAYLOAD_W'({iaddr_i, priv_i, branch_i, SF_START, F_SYNC});
          len_d        = F30_LEN;
        end else if (subformat_i == SF_TRAP) begin
          supported    = 1'b1;
          carries_addr = 1'b1;
          payload_d    = PAYLOAD_W'({tval_i, iaddr_i, thaddr_i, interrupt_i, cause_i,
                                     priv_i, branch_i, SF_TRAP, F_SYNC});
          len_d        = F31_LEN;
        end
      end
      F_ADDR_ONLY: begin
        supported    = 1'b1;
        carries_addr = 1'b1;
        payload_d    = PAYLOAD_W'({upd_bit, notify, addr, F_ADDR_ONLY});
        len_d        = F2_LEN;
      end
      F_DIFF_DELTA: begin
        supported = 1'b1;
        // A full branch map carries no address and leaves latest_q alone.
        if (branches_i == 5'd31) begin
          payload_d = PAYLOAD_W'({branch_map_i, branches_i, F_DIFF_DELTA});
          len_d     = F1M_LEN;
        end else begin
          carries_addr = 1'b1;
          payload_d    = PAYLOAD_W'({upd_bit, notify, addr, branch_map_i, branches_i,
                                     F_DIFF_DELTA});
          len_d        = F1A_LEN;
        end
      end
      default: ;
    endcase
  end

  assign occupancy_o = wptr_q - rptr_q;
  assign pkt_valid_o = (wptr_q != rptr_q);
  assign full        = (occupancy_o == OCC_W'(FIFO_DEPTH));
  assign pop         = pkt_valid_o && pkt_ready_i;
  // A full FIFO still accepts a packet when the head leaves in the same cycle.
  assign wr_en       = req_valid_i && supported && (!full || pop);

  assign overflow_o         = req_valid_i && supported && full && !pop;
  assign branch_map_flush_o = wr_en && (format_i == F_DIFF_DELTA);
  assign lost_o             = lost_q;

  // Storage is not reset, so the head is masked until it holds a packet.
  assign pkt_payload_o = pkt_valid_o ? pay_mem_q[rptr_q[PTR_W-1:0]] : '0;
  assign pkt_len_o     = pkt_valid_o ? len_mem_q[rptr_q[PTR_W-1:0]] : '0;

  always_comb begin
    wptr_d   = wptr_q + OCC_W'(wr_en);
    rptr_d   = rptr_q + OCC_W'(pop);
    latest_d = (wr_en && carries_addr) ? iaddr_i : latest_q;
    lost_d   = overflow_o ? 1'b1 : (clear_lost_i ? 1'b0 : lost_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      latest_q <= '0;
      lost_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      latest_q <= latest_d;
      lost_q   <= lost_d;
    end
  end

  // NOTE: the packet array has no reset; pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      pay_mem_q[wptr_q[PTR_W-1:0]] <= payload_d;
      len_mem_q[wptr_q[PTR_W-1:0]] <= len_d;
    end
  end

endmodule

// File: tb/tb_trdb_packet_emitter_q.sv
// Bench for trdb_packet_emitter_q: directed cases with literal expectations plus
// randomized traffic checked every cycle against a queue-based packet model.
module tb_trdb_packet_emitter_q;

  localparam int PW    = 78;
  localparam int LW    = 4;
  localparam int OW    = 3;
  localparam int DEPTH = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req_valid_i, full_address_i;
  logic [1:0]    format_i, subformat_i;
  logic          branch_i, interrupt_i, thaddr_i, updiscon_i;
  logic [1:0]    priv_i;
  logic [4:0]    cause_i;
  logic [31:0]   iaddr_i, tval_i;
  logic [4:0]    branches_i;
  logic [30:0]   branch_map_i;
  logic          pkt_valid_o, pkt_ready_i;
  logic [PW-1:0] pkt_payload_o;
  logic [LW-1:0] pkt_len_o;
  logic          branch_map_flush_o, overflow_o, lost_o, clear_lost_i;
  logic [OW-1:0] occupancy_o;

  trdb_packet_emitter_q #(
    .XLEN(32), .PRIV_LEN(2), .CAUSE_LEN(5), .BMAP_LEN(31), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i),
    .format_i(format_i), .subformat_i(subformat_i), .full_address_i(full_address_i),
    .branch_i(branch_i), .interrupt_i(interrupt_i), .thaddr_i(thaddr_i),
    .updiscon_i(updiscon_i), .priv_i(priv_i), .cause_i(cause_i),
    .iaddr_i(iaddr_i), .tval_i(tval_i), .branches_i(branches_i),
    .branch_map_i(branch_map_i), .pkt_valid_o(pkt_valid_o), .pkt_ready_i(pkt_ready_i),
    .pkt_payload_o(pkt_payload_o), .pkt_len_o(pkt_len_o),
    .branch_map_flush_o(branch_map_flush_o), .overflow_o(overflow_o),
    .lost_o(lost_o), .clear_lost_i(clear_lost_i), .occupancy_o(occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [PW-1:0] pay;
    int            len;
  } ent_t;

  ent_t          q[$];
  logic [31:0]   m_latest;
  logic          m_lost;
  logic [PW-1:0] m_pay;
  int            m_pos;
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Appends a field of w bits at the current bit position of the model packet.
  function automatic void put(input logic [63:0] v, input int w);
    for (int i = 0; i < w; i++) begin
      m_pay[m_pos] = v[i];
      m_pos++;
    end
  endfunction

  // Checks all outputs against the model, then advances the model by one cycle.
  task automatic cmp_cycle();
    logic        sup, carries, pop, can, wr, over;
    logic [31:0] a;
    ent_t        e;
    check("pkt_valid", pkt_valid_o, q.size() != 0);
    check("occupancy", occupancy_o, q.size());
    check("lost", lost_o, m_lost);
    if (q.size() != 0) begin
      check("payload", pkt_payload_o, q[0].pay);
      check("len", pkt_len_o, q[0].len);
    end
    sup     = req_valid_i && format_i != 0 && !(format_i == 3 && subformat_i > 1);
    carries = format_i == 3 || format_i == 2 || (format_i == 1 && branches_i != 31);
    pop     = q.size() != 0 && pkt_ready_i;
    can     = q.size() < DEPTH || pop;
    wr      = sup && can;
    over    = sup && !can;
    check("overflow", overflow_o, over);
    check("flush", branch_map_flush_o, wr && format_i == 1);
    a = full_address_i ? iaddr_i : iaddr_i - m_latest;
    m_pay = '0;
    m_pos = 0;
    case (format_i)
      2'd3: begin
        put(3, 2); put(subformat_i, 2); put(branch_i, 1); put(priv_i, 2);
        if (subformat_i == 1) begin
          put(cause_i, 5); put(interrupt_i, 1); put(thaddr_i, 1);
          put(iaddr_i, 32); put(tval_i, 32);
        end else put(iaddr_i, 32);
      end
      2'd2: begin
        put(2, 2); put(a, 32); put(a[31], 1); put(a[31] ^ updiscon_i, 1);
      end
      2'd1: begin
        put(1, 2); put(branches_i, 5); put(branch_map_i, 31);
        if (branches_i != 31) begin
          put(a, 32); put(a[31], 1); put(a[31] ^ updiscon_i, 1);
        end
      end
      default: ;
    endcase
    e.pay = m_pay;
    e.len = (m_pos + 7) / 8;
    if (pop) void'(q.pop_front());
    if (wr) begin
      q.push_back(e);
      if (carries) m_latest = iaddr_i;
    end
    if (over) m_lost = 1'b1;
    else if (clear_lost_i) m_lost = 1'b0;
  endtask

  task automatic step();
    @(negedge clk_i);
    cmp_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    req_valid_i  = 1'b0;
    clear_lost_i = 1'b0;
  endtask

  task automatic set_req(input logic [1:0] fmt, input logic [1:0] sub, input logic full,
                         input logic [31:0] ia, input logic [4:0] br, input logic [30:0] map);
    req_valid_i    = 1'b1;
    format_i       = fmt;
    subformat_i    = sub;
    full_address_i = full;
    iaddr_i        = ia;
    branches_i     = br;
    branch_map_i   = map;
  endtask

  initial begin
    rst_ni = 1'b0;
    idle();
    format_i = '0; subformat_i = '0; full_address_i = 1'b0;
    branch_i = 1'b0; interrupt_i = 1'b0; thaddr_i = 1'b0; updiscon_i = 1'b0;
    priv_i = '0; cause_i = '0; iaddr_i = '0; tval_i = '0;
    branches_i = '0; branch_map_i = '0; pkt_ready_i = 1'b0;
    m_latest = '0; m_lost = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    #1;
    check("reset pkt_valid", pkt_valid_o, 0);
    check("reset occupancy", occupancy_o, 0);
    check("reset lost", lost_o, 0);
    check("reset payload", pkt_payload_o, 0);
    check("reset len", pkt_len_o, 0);

    // F3.0 start packet.
    set_req(3, 0, 1, 32'h8000_0000, 0, 0);
    priv_i = 2'd3; branch_i = 1'b1;
    step();
    idle();
    check("f30 valid", pkt_valid_o, 1);
    check("f30 len", pkt_len_o, 5);
    check("f30 fmt", pkt_payload_o[1:0], 3);
    check("f30 sub", pkt_payload_o[3:2], 0);
    check("f30 iaddr", pkt_payload_o[38:7], 32'h8000_0000);
    pkt_ready_i = 1'b1;
    step(); step();

    // F3.0 then F2 deltas.
    branch_i = 1'b0; priv_i = 2'd1;
    set_req(3, 0, 0, 32'h1000, 0, 0);
    step();
    set_req(2, 0, 0, 32'h1010, 0, 0);
    updiscon_i = 1'b1;
    step();
    check("f2 addr", pkt_payload_o[33:2], 32'h10);
    check("f2 notify", pkt_payload_o[34], 0);
    check("f2 updiscon", pkt_payload_o[35], 1);
    check("f2 len", pkt_len_o, 5);
    set_req(2, 0, 0, 32'h0FF0, 0, 0);
    updiscon_i = 1'b0;
    step();
    check("f2 neg addr", pkt_payload_o[33:2], 32'hFFFF_FFE0);
    check("f2 neg notify", pkt_payload_o[34], 1);
    check("f2 neg updiscon", pkt_payload_o[35], 1);

    // F1 full map, then F1 with address against the older latest.
    set_req(1, 0, 0, 32'h9999_0000, 5'd31, 31'h7FFF_FFFF);
    #1 check("f1 map flush", branch_map_flush_o, 1);
    step();
    check("f1 map len", pkt_len_o, 5);
    check("f1 map field", pkt_payload_o[37:7], 31'h7FFF_FFFF);
    set_req(1, 0, 0, 32'h1010, 5'd3, 31'h5);
    step();
    check("f1 addr len", pkt_len_o, 9);
    check("f1 delta", pkt_payload_o[69:38], 32'h20);
    set_req(3, 1, 0, 32'h2000, 0, 0);
    cause_i = 5'd7; tval_i = 32'hDEAD_BEEF;
    step();
    check("f31 len", pkt_len_o, 10);
    check("f31 sub", pkt_payload_o[3:0], 4'b0111);
    idle();
    step(); step();

    // Overflow, loss flag, and push-while-full-and-popping.
    pkt_ready_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      set_req(2, 0, 1, 32'h100 * k, 0, 0);
      step();
    end
    set_req(2, 0, 1, 32'h500, 0, 0);
    #1 check("ovf pulse", overflow_o, 1);
    step();
    idle();
    check("ovf occupancy", occupancy_o, 4);
    check("ovf lost", lost_o, 1);
    clear_lost_i = 1'b1;
    step();
    clear_lost_i = 1'b0;
    check("lost cleared", lost_o, 0);
    set_req(2, 0, 0, 32'h410, 0, 0);
    pkt_ready_i = 1'b1;
    #1 check("full+pop no ovf", overflow_o, 0);
    step();
    idle();
    check("full+pop occupancy", occupancy_o, 4);
    step(); step(); step();
    check("wrap delta", pkt_payload_o[33:2], 32'h10);
    step(); step();

    // Unsupported requests.
    set_req(0, 0, 1, 32'h1234, 0, 0);
    #1 check("fmt0 no flush", branch_map_flush_o, 0);
    step();
    set_req(3, 2, 1, 32'h5678, 0, 0);
    #1 check("sub2 no ovf", overflow_o, 0);
    step();
    idle();
    step();
    check("unsupported occupancy", occupancy_o, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      req_valid_i    = $urandom_range(0, 99) < 65;
      format_i       = 2'($urandom_range(0, 3));
      subformat_i    = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3))
                                                   : 2'($urandom_range(0, 1));
      full_address_i = 1'($urandom_range(0, 1));
      iaddr_i        = ($urandom_range(0, 1) == 1) ? $urandom
                       : m_latest + 32'($urandom_range(0, 512)) - 32'd256;
      branches_i     = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      branch_map_i   = 31'($urandom);
      tval_i         = $urandom;
      cause_i        = 5'($urandom);
      priv_i         = 2'($urandom);
      {branch_i, interrupt_i, thaddr_i, updiscon_i} = 4'($urandom);
      pkt_ready_i    = ((i / 64) % 2 == 0) ? ($urandom_range(0, 99) < 30)
                                           : ($urandom_range(0, 99) < 80);
      clear_lost_i   = $urandom_range(0, 19) == 0;
      step();
    end

    // Reset with packets queued.
    idle();
    pkt_ready_i = 1'b1;
    repeat (6) step();
    pkt_ready_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      set_req(2, 0, 1, 32'h3000 + k, 0, 0);
      step();
    end
    idle();
    check("pre-reset occupancy", occupancy_o, 3);
    rst_ni = 1'b0;
    #1;
    check("mid reset valid", pkt_valid_o, 0);
    check("mid reset occupancy", occupancy_o, 0);
    check("mid reset payload", pkt_payload_o, 0);
    check("mid reset len", pkt_len_o, 0);
    check("mid reset lost", lost_o, 0);
    q.delete();
    m_latest = '0;
    m_lost   = 1'b0;
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    pkt_ready_i = 1'b1;
    set_req(2, 0, 0, 32'h40, 0, 0);
    step();
    idle();
    check("post-reset delta", pkt_payload_o[33:2], 32'h40);
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
